// File: rtl/sine_seq_pkg.sv
// Shared types and default widths for the sine sample sequencer.
package sine_seq_pkg;

  localparam int SEL_W      = 6;
  localparam int ACC_W_DEF  = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator: clears on clr, adds inc when en, flags carry-out as wrap.
module sine_phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic [ACC_W-1:0] phase,
  output logic             wrap
);

  logic [ACC_W:0] sum;

  assign sum  = {1'b0, phase} + {1'b0, inc};
  // wrap only means something on a cycle where the phase actually advances
  assign wrap = en & sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sine_seq_ctrl.sv
// Sine sample sequencer: steps the 64:1 mux select, registers the sample and
// hands it downstream with valid/ready, running bursts of whole periods.
module sine_seq_ctrl
  import sine_seq_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic [CNT_W-1:0]  num_periods,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // Handshake: a sample moves downstream on any rising edge where
  // sample_valid and sample_ready are both high; sample holds until then.

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  freq_q;
  logic [CNT_W-1:0]  nper_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  phase;
  logic              stop_q;
  logic              done_d;
  logic              adv;
  logic              wrap;
  logic              launch;
  logic              last;

  assign launch = (state_q == IDLE) && start;
  assign adv    = (state_q == RUN) && (!sample_valid || sample_ready);

  sine_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (launch),
    .en    (adv),
    .inc   (freq_q),
    .phase (phase),
    .wrap  (wrap)
  );

  // A wrap closes a period; the run ends there if the burst is complete or a stop is pending.
  assign last = wrap && (((nper_q != '0) && ((cnt_q + CNT_W'(1)) == nper_q)) || stop_q || stop);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        if (last) begin
          state_d = FLUSH;
        end else if (sample_valid && !sample_ready) begin
          state_d = STALL;
        end
      end
      STALL: if (sample_ready) state_d = RUN;
      FLUSH: begin
        if (!sample_valid || sample_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      freq_q       <= '0;
      nper_q       <= '0;
      cnt_q        <= '0;
      stop_q       <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (launch) begin
        freq_q <= freq_word;
        nper_q <= num_periods;
        cnt_q  <= '0;
      end else if (wrap) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == FLUSH) && (state_d == IDLE)) begin
        stop_q <= 1'b0;
      end else if (((state_q == RUN) || (state_q == STALL)) && stop) begin
        stop_q <= 1'b1;
      end
      if (adv) begin
        sample       <= mux_data;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  assign sel       = phase[ACC_W-1 -: SEL_W];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Directed bench for sine_seq_ctrl: run-scenario table plus reset and
// zero-frequency sequences, with a sample scoreboard.
module tb_sine_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] freq_word;
  logic [7:0]  num_periods;
  logic [5:0]  sel;
  logic [15:0] mux_data;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] freq;
    logic [7:0]  nper;
    int          stall_at;
    int          stop_at;
    int          start_at;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  sine_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .freq_word    (freq_word),
    .num_periods  (num_periods),
    .sel          (sel),
    .mux_data     (mux_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Distinguishable table entry per select value.
  function automatic logic [15:0] rom(input logic [5:0] s);
    return {4'hA, s, s};
  endfunction

  assign mux_data = rom(sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   got, dones, stall_left;
    bit   stalled, stopped, restarted, hold_ok, finished;
    logic [15:0] held, e;
    logic [5:0]  held_sel;
    logic [31:0] ph;
    exp_q.delete();
    for (int k = 0; k < v.exp_n; k++) begin
      ph = 32'(k) * 32'(v.freq);
      exp_q.push_back(rom(ph[15:10]));
    end
    got = 0; dones = 0; stall_left = 0;
    stalled = 0; stopped = 0; restarted = 0; hold_ok = 0; finished = 0;
    @(posedge clk); #1;
    freq_word = v.freq; num_periods = v.nper; start = 1'b1; sample_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        if (!hold_ok) begin
          held = sample; held_sel = sel; hold_ok = 1;
        end else begin
          chk("stall_sample", sample, held);
          chk("stall_sel", sel, held_sel);
        end
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_sample act=%0h exp=none", sample);
        end else begin
          e = exp_q.pop_front();
          chk("sample", sample, e);
        end
        got++;
      end
      if (done) begin
        dones++;
        finished = 1;
        chk("busy_at_done", busy, 0);
      end else begin
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        if (!restarted && v.start_at >= 0 && got == v.start_at) begin
          start = 1'b1; freq_word = 16'h0800; restarted = 1;
        end
        if (!stopped && v.stop_at >= 0 && got == v.stop_at) begin
          stop = 1'b1; stopped = 1;
        end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) sample_ready = 1'b1;
        end else if (!stalled && v.stall_at >= 0 && got == v.stall_at) begin
          sample_ready = 1'b0; stall_left = 5; stalled = 1;
        end
      end
    end
    chk("run_finished", finished, 1);
    start = 1'b0; stop = 1'b0; sample_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("sample_count", got, v.exp_n);
    chk("exp_left", exp_q.size(), 0);
    chk("done_once", dones, 1);
    chk("busy_idle", busy, 0);
    chk("valid_idle", sample_valid, 0);
  endtask

  initial begin
    vecs[0] = '{freq: 16'h0400, nper: 8'd1, stall_at: -1, stop_at: -1, start_at: -1, exp_n: 64};
    vecs[1] = '{freq: 16'h0800, nper: 8'd2, stall_at: -1, stop_at: -1, start_at: -1, exp_n: 64};
    vecs[2] = '{freq: 16'h0400, nper: 8'd0, stall_at: 10, stop_at: 40, start_at: -1, exp_n: 64};
    vecs[3] = '{freq: 16'h0400, nper: 8'd0, stall_at: -1, stop_at: 20, start_at: -1, exp_n: 64};
    vecs[4] = '{freq: 16'h0400, nper: 8'd1, stall_at: -1, stop_at: -1, start_at: 5,  exp_n: 64};
    vecs[5] = '{freq: 16'h0300, nper: 8'd1, stall_at: -1, stop_at: -1, start_at: -1, exp_n: 86};

    rst = 1'b1; start = 1'b0; stop = 1'b0; freq_word = '0; num_periods = '0;
    sample_ready = 1'b1;
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset in the middle of a run
    begin
      int got;
      got = 0;
      @(posedge clk); #1;
      freq_word = 16'h0400; num_periods = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 200 && got < 30; cyc++) begin
        @(negedge clk);
        if (sample_valid && sample_ready) got++;
      end
      chk("mid_reached", got, 30);
      #2; rst = 1'b1; #1;
      chk("mid_rst_sel", sel, 0);
      chk("mid_rst_sample", sample, 0);
      chk("mid_rst_valid", sample_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      repeat (2) begin
        @(negedge clk);
        chk("rst_hold_done", done, 0);
      end
      rst = 1'b0;
      run_vec(vecs[0]);
    end

    // zero frequency: select parks at 0 and stop never lands
    begin
      @(posedge clk); #1;
      freq_word = 16'h0000; num_periods = 8'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1; stop = 1'b1;
      @(posedge clk); #1; stop = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i % 8 == 0) begin
          chk("f0_busy", busy, 1);
          chk("f0_sample", sample, rom(6'd0));
          chk("f0_done", done, 0);
        end
      end
      #2; rst = 1'b1; #1;
      chk("f0_rst_busy", busy, 0);
      @(negedge clk); rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_seq_ctrl.md
# sine_seq_ctrl

Sample sequencer for the 64-entry sine wave generator. Owns a phase accumulator that drives the 6-bit select of the 64:1 16-bit sample mux, captures the selected sample into a registered output stage, and delivers it downstream over a valid/ready handshake. Supports continuous or fixed-period-count bursts, graceful stop on period boundary, and backpressure.

## Interface
- `ACC_W`, 16: phase accumulator width; select = `phase[ACC_W-1 -: 6]`
- `DATA_W`, 16: sample width (matches mux data width)
- `CNT_W`, 8: period counter width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high; one clock domain
- `start`  in  1  begin run (sampled only in IDLE)
- `stop`  in  1  request graceful stop at next period wrap (sampled only in RUN/STALL)
- `freq_word`  in  ACC_W  phase increment, latched on accepted `start`
- `num_periods`  in  CNT_W  periods to generate, latched on `start`; 0 = continuous
- `sel`  out  6  mux select
- `mux_data`  in  DATA_W  combinational mux output for current `sel`
- `sample`  out  DATA_W  registered sample
- `sample_valid`  out  1  `sample` holds an unconsumed value
- `sample_ready`  in  1  downstream accepts when high with `sample_valid`
- `busy`  out  1  high in RUN/STALL/FLUSH
- `done`  out  1  one-cycle pulse when run completes

## Operation
- States: IDLE, RUN, STALL, FLUSH.
- IDLE: `start`=1 → latch `freq_word`, `num_periods`, clear phase and period count, go RUN. Other inputs ignored.
- Advance condition `adv` = RUN and (`!sample_valid` or `sample_ready`). On `adv`: `sample` <= `mux_data`, `sample_valid` <= 1, phase <= phase + freq (mod 2^ACC_W), `sel` follows new phase.
- Wrap = carry out of the phase addition on an `adv` cycle. On wrap, period count increments.
- RUN → STALL when `sample_valid` and `!sample_ready`; STALL → RUN when `sample_ready`. Phase and `sel` frozen in STALL.
- End of run: on a wrap when (`num_periods`≠0 and count+1 == `num_periods`) or a stop is pending → go FLUSH, no further samples captured.
- FLUSH: wait until the last sample is consumed (`sample_valid` drops), then pulse `done`, go IDLE.
- `stop` is a sticky request: set in RUN/STALL, cleared on entry to IDLE. `start` outside IDLE and `stop` in IDLE/FLUSH are ignored.
- `freq_word`=0: `sel` stays 0, no wraps; continuous until `stop`, which takes effect never (documented limitation; only reset exits).
- `sample_valid` clears on `sample_ready` when no new capture in the same cycle.

## Timing
- Reset values: state IDLE, phase 0, `sel` 0, `sample` 0, `sample_valid` 0, `busy` 0, `done` 0, counters 0.
- `sel` is registered from phase; `mux_data` must settle within one cycle.
- `start` at edge N → RUN from N; first capture at edge N+1 (`sel`=0, sample index 0); `sample_valid` high after N+1.
- Without backpressure, one sample per clock.
- `done` asserted the cycle after the final sample's handshake; `busy` deasserts the same cycle.
- Reset mid-run: all outputs to reset values immediately; in-flight sample discarded, no `done`.

## Structure
- Package `sine_seq_pkg`: state enum (IDLE, RUN, STALL, FLUSH), `SEL_W`=6, default widths.
- Sub-module `sine_phase_acc`: registered accumulator with enable, clear, carry-out wrap flag; controller FSM and output stage in the top.

## Test plan
- `freq_word`=0x0400, `num_periods`=1, ready tied 1 → 64 samples, `sel` 0..63 in order, `done` once, `busy` low after.
- `freq_word`=0x0800, `num_periods`=2 → 64 samples, `sel` steps 0,2,..,62 twice.
- `freq_word`=0x0400, continuous, ready low 5 cycles at sample 10 → `sample` and `sel` hold, no sample lost or repeated.
- Continuous run, `stop` at sample 20 → output continues through index 63, FLUSH, `done`; total 64 samples.
- `start` pulsed mid-run with new `freq_word` → ignored, step unchanged.
- `rst` asserted mid-run at sample 30 → all outputs 0 same cycle; fresh `start` restarts at `sel`=0.
